// File: rtl/cache_pkg.sv
// Shared types and defaults for the 2-way cache and its backing-memory responder.
package cache_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned RAM_ADDR_BITS = 10;
  localparam int unsigned RAM_LATENCY   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ram_state_t;

  // Request payload as seen on the cache-to-RAM bus; any change is a new request.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] addr;
    logic              wr;
  } ram_req_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Backing-memory responder: detects requests as input changes, completes them
// after a fixed latency, and keeps saturating read/write statistics.
module ram_responder
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS = RAM_ADDR_BITS,
  parameter int unsigned LATENCY   = RAM_LATENCY,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data,
  input  logic [WORD_W-1:0] addr,
  input  logic              wr,
  output logic              response,
  output logic [WORD_W-1:0] out,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned LAT_W = 8;

  ram_req_t          req_c;
  ram_req_t          req_q;
  ram_state_t        state;
  logic [LAT_W-1:0]  cnt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic                 new_req_c;
  logic                 done_c;
  logic                 rd_done_c;
  logic                 wr_done_c;
  logic [ADDR_BITS-1:0] idx_c;

  assign req_c     = {data, addr, wr};
  assign new_req_c = (req_c != req_q);
  assign done_c    = (state == BUSY) && !new_req_c && (cnt == '0);
  assign rd_done_c = done_c && !req_q.wr;
  assign wr_done_c = done_c && req_q.wr;
  assign idx_c     = req_q.addr[ADDR_BITS-1:0];

  // Request detection outranks the countdown, so a change mid-access restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      state    <= IDLE;
      cnt      <= '0;
      response <= 1'b1;
      out      <= '0;
    end else if (new_req_c) begin
      req_q    <= req_c;
      response <= 1'b0;
      cnt      <= LAT_W'(LATENCY - 1);
      state    <= BUSY;
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        cnt <= cnt - LAT_W'(1);
      end else begin
        response <= 1'b1;
        state    <= IDLE;
        if (!req_q.wr) begin
          out <= mem[idx_c];
        end
      end
    end
  end

  // Array has no reset so it maps onto a plain single-port RAM.
  always_ff @(posedge clk) begin
    if (wr_done_c) begin
      mem[idx_c] <= req_q.data;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_done_c),
    .clear (1'b0),
    .count (rd_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_done_c),
    .clear (1'b0),
    .count (wr_count)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed requests push expected
// completions, a monitor pops them when response returns high.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] addr = '0;
  logic        wr = 1'b0;
  logic        response;
  logic [31:0] out;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  logic [31:0] data2 = '0;
  logic [31:0] addr2 = '0;
  logic        wr2 = 1'b0;
  logic        response2;
  logic [31:0] out2;
  logic [1:0]  rd_count2;
  logic [1:0]  wr_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] out;
    int          rd;
    int          wr;
    int          low;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ram_responder #(.ADDR_BITS(10), .LATENCY(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .addr     (addr),
    .wr       (wr),
    .response (response),
    .out      (out),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  ram_responder #(.ADDR_BITS(10), .LATENCY(1), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data2),
    .addr     (addr2),
    .wr       (wr2),
    .response (response2),
    .out      (out2),
    .rd_count (rd_count2),
    .wr_count (wr_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Drive a request on the next falling edge and record its expected completion.
  task automatic issue(input logic [31:0] d, input logic [31:0] a, input logic w,
                       input string nm, input logic [31:0] eo, input int erd,
                       input int ewr, input int elow);
    exp_t e;
    @(negedge clk);
    data = d; addr = a; wr = w;
    e.name = nm; e.out = eo; e.rd = erd; e.wr = ewr; e.low = elow;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm);
    bit done;
    done = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (response) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Monitor: count low cycles and compare on each return of response to 1.
  initial begin
    int low;
    exp_t e;
    low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low = 0;
      end else if (!response) begin
        low++;
      end else if (low > 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'(low), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_out"}, out, e.out);
          chk({e.name, "_rd"}, 32'(rd_count), 32'(e.rd));
          chk({e.name, "_wr"}, 32'(wr_count), 32'(e.wr));
          chk({e.name, "_low"}, 32'(low), 32'(e.low));
        end
        low = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_response", 32'(response), 32'd1);
    chk("reset_out", out, 32'd0);
    chk("reset_rd", 32'(rd_count), 32'd0);
    chk("reset_wr", 32'(wr_count), 32'd0);
    rst_n = 1'b1;

    // Preload known contents.
    issue(32'h0, 32'd5, 1'b1, "init5", 32'h0, 0, 1, 4);   wait_done("init5");
    issue(32'h77, 32'd7, 1'b1, "init7", 32'h0, 0, 2, 4);  wait_done("init7");
    issue(32'h99, 32'd9, 1'b1, "init9", 32'h0, 0, 3, 4);  wait_done("init9");

    // Reset in the middle of a write: write is dropped, no completion expected.
    @(negedge clk);
    data = 32'hDEAD; addr = 32'd5; wr = 1'b1;
    @(negedge clk);
    chk("midwrite_busy", 32'(response), 32'd0);
    #2;
    rst_n = 1'b0;
    data = '0; addr = '0; wr = 1'b0;
    #1;
    chk("midwrite_reset_response", 32'(response), 32'd1);
    chk("midwrite_reset_wr", 32'(wr_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0, 32'd5, 1'b0, "rd5_after_reset", 32'h0, 1, 0, 4);          wait_done("rd5");
    issue(32'h12345678, 32'd3, 1'b1, "wr3", 32'h0, 1, 1, 4);               wait_done("wr3");
    issue(32'h0, 32'd3, 1'b0, "rd3", 32'h12345678, 2, 1, 4);               wait_done("rd3");
    issue(32'hAAAA0001, 32'h403, 1'b1, "wr_alias", 32'h12345678, 2, 2, 4); wait_done("wr_alias");
    issue(32'h0, 32'h003, 1'b0, "rd_alias", 32'hAAAA0001, 3, 2, 4);        wait_done("rd_alias");

    // Abort: write to 7 replaced two cycles later by a read of 9.
    @(negedge clk);
    data = 32'd1; addr = 32'd7; wr = 1'b1;
    repeat (2) @(negedge clk);
    data = 32'h0; addr = 32'd9; wr = 1'b0;
    begin
      exp_t e;
      e.name = "abort_rd9"; e.out = 32'h99; e.rd = 4; e.wr = 2; e.low = 6;
      sb.push_back(e);
    end
    wait_done("abort");
    issue(32'h0, 32'd7, 1'b0, "rd7_unchanged", 32'h77, 5, 2, 4); wait_done("rd7");

    // Inputs held: no new request.
    repeat (10) @(negedge clk);
    chk("hold_response", 32'(response), 32'd1);
    chk("hold_rd", 32'(rd_count), 32'd5);

    // Saturation on the CNT_W=2, LATENCY=1 instance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data2 = '0; addr2 = (i % 2 == 0) ? 32'd1 : 32'd2; wr2 = 1'b0;
      @(negedge clk);
      chk($sformatf("sat%0d_low", i), 32'(response2), 32'd0);
      @(negedge clk);
      chk($sformatf("sat%0d_high", i), 32'(response2), 32'd1);
      chk($sformatf("sat%0d_rd", i), 32'(rd_count2), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
